// File: rtl/invaders_march_if.sv
// ---------------------------------------------------------------------------
// invaders_march_if
//
// Signal bundle between the game core and the formation movement scheduler.
//
//   frame_tick      one-cycle pulse per video frame          (core -> march)
//   gameplay        game state, 00 PLAYING / 01 WIN / 10 OVER (core -> march)
//   invaders_array  live-invader bits, row 1 at [19:10]      (core -> march)
//   x_offset        left pixel of grid column 0              (march -> core)
//   invaders_line   current grid line                        (march -> core)
//   direction       0 = moving right, 1 = moving left        (march -> core)
//   step_pulse      one-cycle pulse per move/descend         (march -> core)
//
// master: the side that drives the game inputs (core / testbench)
// slave : the movement scheduler
// ---------------------------------------------------------------------------
interface invaders_march_if;
    logic        frame_tick;
    logic [1:0]  gameplay;
    logic [19:0] invaders_array;
    logic [7:0]  x_offset;
    logic [3:0]  invaders_line;
    logic        direction;
    logic        step_pulse;

    modport master (
        output frame_tick, gameplay, invaders_array,
        input  x_offset, invaders_line, direction, step_pulse
    );

    modport slave (
        input  frame_tick, gameplay, invaders_array,
        output x_offset, invaders_line, direction, step_pulse
    );
endinterface

// File: rtl/invaders_march.sv
// ---------------------------------------------------------------------------
// invaders_march
//
// Formation movement scheduler for the 10x2 invader grid. Counts frames,
// steps the grid horizontally once per period, and at a screen edge drops
// the grid one line and reverses direction. Freezes (HALT) as soon as the
// game leaves the PLAYING state; only reset brings it back.
//
// Ports:
//   clk_36MHz  system clock
//   reset      synchronous, active-high reset
//   bus        invaders_march_if.slave (frame_tick, gameplay, invaders_array
//              in; x_offset, invaders_line, direction, step_pulse out)
//
// Build option:
//   INVADERS_SPEEDUP_EN  when defined, the step period is
//                        MIN_PERIOD + PERIOD_PER_INVADER * live_count;
//                        otherwise it is the constant BASE_PERIOD and the
//                        popcount logic is not built.
// ---------------------------------------------------------------------------
module invaders_march #(
    parameter int SCREEN_W           = 240,
    parameter int COL_W              = 16,
    parameter int STEP_PX            = 4,
    parameter int X_START            = 40,
    parameter int START_LINE         = 2,
    parameter int MIN_PERIOD         = 2,
    parameter int PERIOD_PER_INVADER = 2,
    parameter int BASE_PERIOD        = 20
) (
    input  logic        clk_36MHz,
    input  logic        reset,
    invaders_march_if.slave bus
);

    typedef enum logic [1:0] {WAIT, MOVE, DESCEND, HALT} state_t;

    // A zero-length period would make the grid step on every frame with no
    // pacing at all; refuse such a configuration at elaboration.
    if (BASE_PERIOD < 1 || MIN_PERIOD < 1 || PERIOD_PER_INVADER < 0) begin : g_cfg_check
        $error("invaders_march: step period parameters must be positive");
    end

    state_t      state_q, state_d;
    logic        tick_p0;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [7:0]  x_q, x_d;
    logic [3:0]  line_q, line_d;
    logic        dir_q, dir_d;
    logic        pulse_q, pulse_d;

    logic [9:0]  col_alive;
    logic [3:0]  lmin, rmax;
    logic [7:0]  period;
    logic [9:0]  right_sum, left_sum;
    logic        hit_edge;

    function automatic logic [3:0] sat_line(input logic [3:0] line);
        return (line == 4'd15) ? 4'd15 : line + 4'd1;
    endfunction

`ifdef INVADERS_SPEEDUP_EN
    function automatic logic [4:0] popcount20(input logic [19:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 20; i++) n = n + {4'b0000, v[i]};
        return n;
    endfunction

    logic [4:0] alive;
    assign alive  = popcount20(bus.invaders_array);
    assign period = 8'(MIN_PERIOD) + 8'(PERIOD_PER_INVADER) * {3'b000, alive};
`else
    assign period = 8'(BASE_PERIOD);
`endif

    always_comb begin
        col_alive = '0;
        for (int c = 0; c < 10; c++) col_alive[c] = bus.invaders_array[c] | bus.invaders_array[c+10];
    end

    // Scan downwards for lmin and upwards for rmax so the last hit wins.
    always_comb begin
        lmin = '0;
        rmax = '0;
        for (int c = 9; c >= 0; c--) if (col_alive[c]) lmin = 4'(c);
        for (int c = 0; c < 10; c++) if (col_alive[c]) rmax = 4'(c);
    end

    // Widened to 10 bits so x_offset near 255 plus a full grid cannot wrap.
    assign right_sum = {2'b00, x_q} + 10'(STEP_PX) + ({6'b0, rmax} + 10'd1) * 10'(COL_W);
    assign left_sum  = {2'b00, x_q} + {6'b0, lmin} * 10'(COL_W);
    assign hit_edge  = dir_q ? (left_sum < 10'(STEP_PX)) : (right_sum > 10'(SCREEN_W));

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        x_d     = x_q;
        line_d  = line_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        if (state_q != HALT && bus.gameplay != 2'b00) begin
            state_d = HALT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (tick_p0) begin
                        if (({1'b0, fcnt_q} + 9'd1) >= {1'b0, period}) begin
                            fcnt_d  = '0;
                            state_d = MOVE;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end
                MOVE: begin
                    state_d = WAIT;
                    if (bus.invaders_array != '0) begin
                        if (hit_edge) begin
                            state_d = DESCEND;
                        end else begin
                            x_d     = dir_q ? x_q - 8'(STEP_PX) : x_q + 8'(STEP_PX);
                            pulse_d = 1'b1;
                        end
                    end
                end
                DESCEND: begin
                    line_d  = sat_line(line_q);
                    dir_d   = ~dir_q;
                    pulse_d = 1'b1;
                    state_d = WAIT;
                end
                default: ;
            endcase
        end
    end

    // Stage p0: frame_tick is registered before WAIT evaluates it; ticks that
    // land outside WAIT are dropped here so MOVE/DESCEND never see them later.
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            state_q <= WAIT;
            tick_p0 <= 1'b0;
            fcnt_q  <= '0;
            x_q     <= 8'(X_START);
            line_q  <= 4'(START_LINE);
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_p0 <= bus.frame_tick && (state_q == WAIT);
            fcnt_q  <= fcnt_d;
            x_q     <= x_d;
            line_q  <= line_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.x_offset      = x_q;
    assign bus.invaders_line = line_q;
    assign bus.direction     = dir_q;
    assign bus.step_pulse    = pulse_q;

endmodule

// File: doc/invaders_march.md
# invaders_march

Formation movement scheduler for the invader grid. Counts video frames, paces each formation step from the number of live invaders, and steps the grid horizontally. At a screen edge it drops the grid one line and reverses direction. It drives the `invaders_line` consumed by the win/lose tracker, and freezes once the game is no longer in the PLAYING state.

## Interface

Parameters:
- SCREEN_W, 240: playfield width in pixels.
- COL_W, 16: column pitch in pixels. The grid has 10 columns × 2 rows.
- STEP_PX, 4: horizontal pixels per step.
- X_START, 40: x_offset after reset.
- START_LINE, 2: invaders_line after reset.
- MIN_PERIOD, 2: frames per step floor (SPEEDUP_EN).
- PERIOD_PER_INVADER, 2: extra frames per live invader (SPEEDUP_EN).
- BASE_PERIOD, 20: fixed frames per step (no SPEEDUP_EN).

Ports:
- clk_36MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- gameplay  in  2  game state: 00 PLAYING, 01 YOU_WIN, 10 GAME_OVER.
- invaders_array  in  20  live-invader bits. Bit c is row 0, column c; bit c+10 is row 1, column c.
- x_offset  out  8  left pixel of grid column 0.
- invaders_line  out  4  current grid line.
- direction  out  1  0 = moving right, 1 = moving left.
- step_pulse  out  1  one-cycle pulse on every move or descend (sound trigger).

## Operation

- Column c is alive when bit[c] | bit[c+10]. lmin/rmax are the lowest/highest alive column indices.
- alive = popcount(invaders_array), 5 bits, range 0..20.
- period is 8 bits:
  - with SPEEDUP_EN: MIN_PERIOD + PERIOD_PER_INVADER*alive;
  - otherwise: BASE_PERIOD.
- fcnt is an 8-bit frame counter.
- States: WAIT, MOVE, DESCEND, HALT.
- In any state other than HALT, gameplay != 00 forces the next state to HALT. This takes priority, and no output updates that cycle.
- WAIT:
  - On frame_tick: if fcnt+1 >= period (live value), clear fcnt and go to MOVE; else increment fcnt.
  - With no frame_tick, hold.
- MOVE (one cycle):
  - If invaders_array == 0: return to WAIT with no update and no pulse.
  - Right edge hit (direction 0 and x_offset + STEP_PX + (rmax+1)*COL_W > SCREEN_W) or left edge hit (direction 1 and x_offset + lmin*COL_W < STEP_PX): go to DESCEND.
  - Otherwise: x_offset ± STEP_PX, step_pulse, go to WAIT.
  - Edge arithmetic is done at 10 bits, with no wrap.
- DESCEND (one cycle):
  - invaders_line + 1, saturating at 15.
  - Toggle direction; x_offset unchanged.
  - Pulse step_pulse, go to WAIT.
- HALT: all outputs frozen and step_pulse 0. Exit only via reset.
- frame_tick arriving in MOVE or DESCEND is ignored.

## Timing

- Reset values: x_offset = X_START, invaders_line = START_LINE, direction = 0, step_pulse = 0, fcnt = 0, state WAIT.
- Completing frame_tick sampled at edge N → state MOVE after edge N+1. The MOVE decision is registered at edge N+2: updated x_offset, or entry to DESCEND.
- For a move, step_pulse is high during the cycle after edge N+2.
- For a descend, invaders_line, direction and step_pulse update at edge N+3.
- step_pulse is exactly one cycle wide. Consecutive pulses are at least one period of frames apart.
- Reset asserted in any state, including mid-MOVE/DESCEND, wins over every update. Reset values appear after that edge, with no pulse.
- The period shrinking below fcnt (kills) triggers the step on the next frame_tick.

## Configuration

- INVADERS_SPEEDUP_EN defined: the period tracks the live count (fewer invaders → faster march).
- INVADERS_SPEEDUP_EN not defined: constant BASE_PERIOD, and the popcount logic is removed.

## Test plan

- All 20 alive, SPEEDUP_EN, 100 frame_ticks spaced ≥ 8 cycles: first step_pulse after the 42nd tick, x_offset 40→44. Second pulse after tick 84, x_offset 48.
- All alive, fast ticks: 10 moves reach x_offset 80. The 11th step descends: invaders_line 2→3, direction 1, x_offset stays 80, one pulse.
- Only bit 0 alive (rmax = lmin = 0), SPEEDUP_EN: period 4. Moving right, the descend happens only when x_offset + 4 + 16 > 240 (x_offset 224 → descend).
- invaders_array = 0 when MOVE is reached: no pulse, outputs unchanged. Repeated descents from line 14: line saturates at 15.
- gameplay = 10 mid-WAIT, then 200 frame_ticks: state HALT, no step_pulse, outputs frozen. Reset → 40/2/0/0.
- Reset pulsed in the MOVE cycle: next cycle x_offset = 40, step_pulse = 0. Without the macro, the period is 20 frames regardless of invaders_array.
